// File: rtl/psa_serial_addsub_pkg.sv
// Shared constants and types for the serial parallel-subword add/subtract unit.
// Saturation of overflowing lanes is enabled by defining PSA_SAT_EN.
package psa_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int WORD_W = LANES * LANE_W;

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An overflow in a lane always carries the sign of the first operand,
  // so that sign picks the saturation rail.
  function automatic logic [LANE_W-1:0] sat_lane(input logic [LANE_W-1:0] x);
    return x[LANE_W-1] ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/addsub_4bit.sv
// 4-bit two's-complement adder/subtractor with sign-based overflow detection.
module addsub_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       sub,
  output logic [3:0] r,
  output logic       ovf
);

  logic [3:0] y_eff;

  // Subtraction is x + ~y + 1; overflow compares the signs the adder actually
  // sees, which makes y=4'b1000 overflow exactly when x is non-negative.
  assign y_eff = sub ? ~y : y;
  assign r     = x + y_eff + {3'b000, sub};
  assign ovf   = (x[3] == y_eff[3]) & (r[3] != x[3]);

endmodule

// File: rtl/psa_serial_addsub.sv
// Serial PADDSB/PSUBSB: four signed 4-bit lanes through one shared adder, one lane per cycle.
// Optional saturation of overflowing lanes when PSA_SAT_EN is defined.
module psa_serial_addsub
  import psa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum,
  output logic [LANES-1:0]  lane_ovf,
  output logic              error
);

  state_t              state_q;
  logic [1:0]          lane_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   b_q;
  logic                sub_q;
  logic [WORD_W-1:0]   sum_q;
  logic [LANES-1:0]    ovf_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [3:0]          lane_base;
  logic [LANE_W-1:0]   lane_x;
  logic [LANE_W-1:0]   lane_y;
  logic [LANE_W-1:0]   lane_raw;
  logic                lane_ovf_w;
  logic [LANE_W-1:0]   lane_res_d;

  assign lane_base = {lane_q, 2'b00};
  assign lane_x    = a_q[lane_base +: LANE_W];
  assign lane_y    = b_q[lane_base +: LANE_W];

  addsub_4bit u_addsub (
    .x   (lane_x),
    .y   (lane_y),
    .sub (sub_q),
    .r   (lane_raw),
    .ovf (lane_ovf_w)
  );

`ifdef PSA_SAT_EN
  assign lane_res_d = lane_ovf_w ? sat_lane(lane_x) : lane_raw;
`else
  assign lane_res_d = lane_raw;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            sub_q      <= op_sub;
            sum_q      <= '0;
            ovf_q      <= '0;
            lane_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          sum_q[lane_base +: LANE_W] <= lane_res_d;
          ovf_q[lane_q]              <= lane_ovf_w;
          if (lane_q == LAST_LANE) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            lane_q <= lane_q + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign lane_ovf  = ovf_q;
  assign error     = |ovf_q;

endmodule
